// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module  : ctrl_pkg
// Brief   : State, opcode, alu_op and pc_src encodings for control_fsm.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_ADDR = 4'd2,
    MEM       = 4'd3,
    WB_MEM    = 4'd4,
    EXEC_R    = 4'd5,
    WB_R      = 4'd6,
    BRANCH    = 4'd7,
    JUMP      = 4'd8,
    HALT      = 4'd9
  } state_e;

  localparam logic [3:0] OP_LD    = 4'b0000;
  localparam logic [3:0] OP_ST    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_NOT   = 4'b0100;
  localparam logic [3:0] OP_SHL   = 4'b0101;
  localparam logic [3:0] OP_SHR   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_ILL_A = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_JMP   = 4'b1101;
  localparam logic [3:0] OP_ILL_E = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SLT);
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op == OP_ILL_A) || (op == OP_ILL_E);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_outdec.sv
// ============================================================================
// Module  : ctrl_outdec
// Brief   : Combinational strobe decode from state, latched opcode and zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] op_q_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [1:0] alu_op_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       alu_src_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       halted_o
);

  always_comb begin
    alu_op_o     = ALUOP_RTYPE;
    pc_write_o   = 1'b0;
    pc_src_o     = PCSRC_SEQ;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    alu_src_o    = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    halted_o     = 1'b0;

    case (state_i)
      FETCH: begin
        // PC/IR load only on the ready cycle so a stalled fetch advances PC once
        mem_read_o = 1'b1;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
        pc_src_o   = PCSRC_SEQ;
        alu_op_o   = ALUOP_ADD;
      end
      DECODE: begin
        // op_q is not loaded yet, so the illegal check looks at the live opcode
        if (op_is_illegal(opcode_i)) begin
          illegal_o    = 1'b1;
          instr_done_o = 1'b1;
        end
      end
      EXEC_ADDR: begin
        alu_op_o  = ALUOP_ADD;
        alu_src_o = 1'b1;
      end
      MEM: begin
        if (op_q_i == OP_LD) begin
          mem_read_o = 1'b1;
          alu_src_o  = 1'b1;
        end else begin
          mem_write_o  = 1'b1;
          instr_done_o = mem_ready_i;
        end
      end
      WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
      end
      EXEC_R: begin
        alu_op_o  = ALUOP_RTYPE;
        alu_src_o = 1'b0;
      end
      WB_R: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        alu_op_o     = ALUOP_RTYPE;
        instr_done_o = 1'b1;
      end
      BRANCH: begin
        alu_op_o     = ALUOP_SUB;
        pc_src_o     = PCSRC_BRANCH;
        pc_write_o   = (op_q_i == OP_BNE) ? ~zero_i : zero_i;
        instr_done_o = 1'b1;
      end
      JUMP: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PCSRC_JUMP;
        instr_done_o = 1'b1;
      end
      HALT: begin
        halted_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// Module  : control_fsm
// Brief   : Multi-cycle main control unit; state register, op_q, next state.
//           Define CTRL_MEM_WAIT_EN to add the mem_ready wait-state handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
`ifdef CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       mem_rdy;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      FETCH:     if (mem_rdy) state_d = DECODE;
      DECODE: begin
        op_d = opcode;
        if ((opcode == OP_LD) || (opcode == OP_ST))        state_d = EXEC_ADDR;
        else if (op_is_alu(opcode))                        state_d = EXEC_R;
        else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) state_d = BRANCH;
        else if (opcode == OP_JMP)                         state_d = JUMP;
        else if (opcode == OP_HALT)                        state_d = HALT;
        else                                               state_d = FETCH;
      end
      EXEC_ADDR: state_d = MEM;
      MEM:       if (mem_rdy) state_d = (op_q == OP_LD) ? WB_MEM : FETCH;
      WB_MEM:    state_d = FETCH;
      EXEC_R:    state_d = WB_R;
      WB_R:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  ctrl_outdec u_outdec (
    .state_i      (state_q),
    .op_q_i       (op_q),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_rdy),
    .alu_op_o     (alu_op),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .ir_write_o   (ir_write),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .alu_src_o    (alu_src),
    .reg_write_o  (reg_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .instr_done_o (instr_done),
    .illegal_o    (illegal),
    .halted_o     (halted)
  );

endmodule

`default_nettype wire
